preg_alloc_ctrl: RTL and testbench

- Controller between the rename stage and the physical-register free-list FIFO (multi-lane get/put, MAX_IO lanes).
- Sequences FIFO initialisation and grants rename allocation requests all-or-nothing against the current free count and a reserve.
- Feeds commit-stage frees back into the FIFO.
- Keeps a shadow free counter with sticky consistency-error flags for verification and debug.

---
 rtl/preg_alloc_pkg.sv | 18 +
 rtl/preg_alloc_ctrl_popcount.sv | 18 +
 rtl/preg_alloc_ctrl.sv | 158 +++++++++++++++
 tb/tb_preg_alloc_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/preg_alloc_pkg.sv
// Shared types and sizing for the physical-register allocation controller.
package preg_alloc_pkg;

    localparam int unsigned NUM_PREGS = 64;
    localparam int unsigned PREG_W    = 6;
    localparam int unsigned MAX_IO    = 3;

    // Width of fifo_len / free_cnt: must hold the value NUM_PREGS itself.
    localparam int unsigned CNT_W  = $clog2(NUM_PREGS) + 1;
    // Width of a per-cycle lane count (0..MAX_IO).
    localparam int unsigned NREQ_W = $clog2(MAX_IO) + 1;

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    typedef logic [PREG_W-1:0] preg_t;

endpackage

// File: rtl/preg_alloc_ctrl_popcount.sv
// Counts the asserted lanes of a lane-enable vector.
module popcount_lanes #(
    parameter int unsigned LANES = 3,
    parameter int unsigned CNT_W = $clog2(LANES) + 1
) (
    input  logic [LANES-1:0] bits_i,
    output logic [CNT_W-1:0] count_o
);

    // Sum the enable bits.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < LANES; i++) begin
            count_o = count_o + CNT_W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/preg_alloc_ctrl.sv
// Rename-side controller for the physical-register free-list FIFO: sequences FIFO init,
// grants multi-lane allocations all-or-nothing, returns commit frees and keeps a shadow
// free counter with sticky consistency flags.
module preg_alloc_ctrl
    import preg_alloc_pkg::*;
#(
    parameter int unsigned RESERVE     = 0,
    parameter int unsigned INIT_CYCLES = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           reinit_i,
    input  logic                           flush_i,
    input  logic [MAX_IO-1:0]              req_en_i,
    output logic                           req_ready_o,
    output logic                           alloc_valid_o,
    output logic [MAX_IO-1:0]              alloc_lane_en_o,
    output logic [MAX_IO-1:0][PREG_W-1:0]  alloc_preg_o,
    input  logic [MAX_IO-1:0]              free_en_i,
    input  logic [MAX_IO-1:0][PREG_W-1:0]  free_preg_i,
    output logic                           fifo_rst_o,
    output logic [MAX_IO-1:0]              fifo_get_en_o,
    output logic [MAX_IO-1:0]              fifo_put_en_o,
    output logic [MAX_IO-1:0][PREG_W-1:0]  fifo_put_o,
    input  logic [MAX_IO-1:0][PREG_W-1:0]  fifo_gotten_i,
    input  logic [CNT_W-1:0]               fifo_len_i,
    output logic [CNT_W-1:0]               free_cnt_o,
    output logic                           err_underflow_o,
    output logic                           err_mismatch_o
);

    // One extra bit so a double free is visible before saturation.
    localparam int unsigned ICNT_W = CNT_W + 1;
    localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    logic [0:0]                    state_q, state_d;
    logic [INIT_W-1:0]             init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0]              free_cnt_q, free_cnt_d;
    logic                          first_run_q, first_run_d;
    logic                          err_uf_q, err_uf_d;
    logic                          err_mm_q, err_mm_d;
    logic                          alloc_valid_q, alloc_valid_d;
    logic [MAX_IO-1:0]             alloc_lane_en_q, alloc_lane_en_d;
    logic [MAX_IO-1:0][PREG_W-1:0] alloc_preg_q, alloc_preg_d;

    logic [NREQ_W-1:0] n_req, n_free_raw, n_free, n_granted;
    logic [ICNT_W-1:0] need, cnt_sum, cnt_next;
    logic              run, free_ok, grant, overflow;

    popcount_lanes #(
        .LANES(MAX_IO),
        .CNT_W(NREQ_W)
    ) u_pop_req (
        .bits_i (req_en_i),
        .count_o(n_req)
    );

    popcount_lanes #(
        .LANES(MAX_IO),
        .CNT_W(NREQ_W)
    ) u_pop_free (
        .bits_i (free_en_i),
        .count_o(n_free_raw)
    );

    // Grant decision, FIFO handshakes and the shadow counter arithmetic.
    always_comb begin
        run         = (state_q == S_RUN);
        free_ok     = run & ~reinit_i;
        need        = ICNT_W'(n_req) + ICNT_W'(RESERVE);
        req_ready_o = run & ~flush_i & ~reinit_i & (need <= ICNT_W'(free_cnt_q));
        grant       = req_ready_o & (n_req != '0);
        n_granted   = grant ? n_req : '0;
        n_free      = free_ok ? n_free_raw : '0;
        // Grant never exceeds free_cnt, so the subtraction cannot wrap.
        cnt_sum     = ICNT_W'(free_cnt_q) - ICNT_W'(n_granted) + ICNT_W'(n_free);
        overflow    = free_ok & (cnt_sum > ICNT_W'(NUM_PREGS));
        cnt_next    = overflow ? ICNT_W'(NUM_PREGS) : cnt_sum;

        fifo_rst_o    = (state_q == S_INIT);
        fifo_get_en_o = grant ? req_en_i : '0;
        // A double free would corrupt the list, so that cycle's puts are dropped.
        fifo_put_en_o = (free_ok & ~overflow) ? free_en_i : '0;
        fifo_put_o    = free_ok ? free_preg_i : '0;
    end

    // Next-state for the init/run sequencer, counter and sticky error flags.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        free_cnt_d  = free_cnt_q;
        first_run_d = 1'b0;
        err_uf_d    = err_uf_q | overflow;
        // The FIFO length lags by one cycle after init, so skip the first run cycle.
        err_mm_d    = err_mm_q | (run & ~first_run_q & (fifo_len_i != free_cnt_q));
        if (state_q == S_INIT) begin
            free_cnt_d = CNT_W'(NUM_PREGS);
            if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
                state_d     = S_RUN;
                init_cnt_d  = '0;
                first_run_d = 1'b1;
            end else begin
                init_cnt_d = init_cnt_q + 1'b1;
            end
        end else if (reinit_i) begin
            state_d    = S_INIT;
            init_cnt_d = '0;
            free_cnt_d = CNT_W'(NUM_PREGS);
        end else begin
            free_cnt_d = cnt_next[CNT_W-1:0];
        end
    end

    // Registered allocation result; only granted lanes carry a preg.
    always_comb begin
        alloc_valid_d   = grant;
        alloc_lane_en_d = grant ? req_en_i : '0;
        alloc_preg_d    = '0;
        for (int i = 0; i < MAX_IO; i++) begin
            if (grant && req_en_i[i]) begin
                alloc_preg_d[i] = fifo_gotten_i[i];
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= S_INIT;
            init_cnt_q      <= '0;
            free_cnt_q      <= CNT_W'(NUM_PREGS);
            first_run_q     <= 1'b0;
            err_uf_q        <= 1'b0;
            err_mm_q        <= 1'b0;
            alloc_valid_q   <= 1'b0;
            alloc_lane_en_q <= '0;
            alloc_preg_q    <= '0;
        end else begin
            state_q         <= state_d;
            init_cnt_q      <= init_cnt_d;
            free_cnt_q      <= free_cnt_d;
            first_run_q     <= first_run_d;
            err_uf_q        <= err_uf_d;
            err_mm_q        <= err_mm_d;
            alloc_valid_q   <= alloc_valid_d;
            alloc_lane_en_q <= alloc_lane_en_d;
            alloc_preg_q    <= alloc_preg_d;
        end
    end

    assign alloc_valid_o   = alloc_valid_q;
    assign alloc_lane_en_o = alloc_lane_en_q;
    assign alloc_preg_o    = alloc_preg_q;
    assign free_cnt_o      = free_cnt_q;
    assign err_underflow_o = err_uf_q;
    assign err_mismatch_o  = err_mm_q;

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Randomized bench for preg_alloc_ctrl with a queue-based free-list FIFO and a
// behavioural model of the grant/free/counter rules, plus directed scenarios.
module tb_preg_alloc_ctrl;
    import preg_alloc_pkg::*;

    localparam int RES   = 0;
    localparam int INITC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic reinit = 1'b0;
    logic flush = 1'b0;
    logic [MAX_IO-1:0] req_en = '0;
    logic [MAX_IO-1:0] free_en = '0;
    logic [MAX_IO-1:0][PREG_W-1:0] free_preg = '0;

    logic req_ready, alloc_valid, fifo_rst, err_underflow, err_mismatch;
    logic [MAX_IO-1:0] alloc_lane_en, fifo_get_en, fifo_put_en;
    logic [MAX_IO-1:0][PREG_W-1:0] alloc_preg, fifo_put;
    logic [MAX_IO-1:0][PREG_W-1:0] fifo_gotten;
    logic [CNT_W-1:0] fifo_len = '0;
    logic [CNT_W-1:0] free_cnt;

    // Second instance with a reserve of one entry, driven only by req_en_r.
    logic [MAX_IO-1:0] req_en_r = '0;
    logic req_ready_r, alloc_valid_r, fifo_rst_r, err_uf_r, err_mm_r;
    logic [MAX_IO-1:0] alloc_lane_en_r, get_en_r, put_en_r;
    logic [MAX_IO-1:0][PREG_W-1:0] alloc_preg_r, put_r;
    logic [CNT_W-1:0] free_cnt_r;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    preg_alloc_ctrl #(.RESERVE(RES), .INIT_CYCLES(INITC)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .reinit_i(reinit), .flush_i(flush),
        .req_en_i(req_en), .req_ready_o(req_ready), .alloc_valid_o(alloc_valid),
        .alloc_lane_en_o(alloc_lane_en), .alloc_preg_o(alloc_preg),
        .free_en_i(free_en), .free_preg_i(free_preg), .fifo_rst_o(fifo_rst),
        .fifo_get_en_o(fifo_get_en), .fifo_put_en_o(fifo_put_en), .fifo_put_o(fifo_put),
        .fifo_gotten_i(fifo_gotten), .fifo_len_i(fifo_len), .free_cnt_o(free_cnt),
        .err_underflow_o(err_underflow), .err_mismatch_o(err_mismatch)
    );

    preg_alloc_ctrl #(.RESERVE(1), .INIT_CYCLES(INITC)) u_res (
        .clk_i(clk), .rst_ni(rst_n), .reinit_i(1'b0), .flush_i(1'b0),
        .req_en_i(req_en_r), .req_ready_o(req_ready_r), .alloc_valid_o(alloc_valid_r),
        .alloc_lane_en_o(alloc_lane_en_r), .alloc_preg_o(alloc_preg_r),
        .free_en_i('0), .free_preg_i('0), .fifo_rst_o(fifo_rst_r),
        .fifo_get_en_o(get_en_r), .fifo_put_en_o(put_en_r), .fifo_put_o(put_r),
        .fifo_gotten_i('0), .fifo_len_i(free_cnt_r), .free_cnt_o(free_cnt_r),
        .err_underflow_o(err_uf_r), .err_mismatch_o(err_mm_r)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- free-list FIFO environment ----------------
    int fq[$];
    int fifo_ver = 0;
    logic [MAX_IO-1:0] cap_get, cap_put;
    logic [MAX_IO-1:0][PREG_W-1:0] cap_data;
    logic cap_rst;

    always @(negedge clk) begin
        cap_get  = fifo_get_en;
        cap_put  = fifo_put_en;
        cap_data = fifo_put;
        cap_rst  = fifo_rst;
    end

    always @(posedge clk) begin
        if (cap_rst === 1'b1) begin
            fq.delete();
            for (int i = 0; i < NUM_PREGS; i++) fq.push_back(i);
        end else begin
            for (int i = 0; i < MAX_IO; i++)
                if (cap_get[i] === 1'b1 && fq.size() > 0) void'(fq.pop_front());
            for (int i = 0; i < MAX_IO; i++)
                if (cap_put[i] === 1'b1) fq.push_back(int'(cap_data[i]));
        end
        fifo_len <= CNT_W'(fq.size());
        fifo_ver <= fifo_ver + 1;
    end

    // Lane i sees the entry ranked by the number of getting lanes below it.
    always @(fifo_get_en or fifo_ver) begin
        int k;
        k = 0;
        for (int i = 0; i < MAX_IO; i++) begin
            fifo_gotten[i] = (k < fq.size()) ? PREG_W'(fq[k]) : '0;
            if (fifo_get_en[i] === 1'b1) k++;
        end
    end

    // ---------------- behavioural model ----------------
    bit m_run, m_first, m_uf, m_mm;
    int m_icnt, m_free;
    bit a_v;
    logic [MAX_IO-1:0] a_lane;
    logic [MAX_IO-1:0][PREG_W-1:0] a_preg;
    bit n_run, n_first, n_uf, n_mm, n_v;
    int n_icnt, n_free;
    logic [MAX_IO-1:0] n_lane;
    logic [MAX_IO-1:0][PREG_W-1:0] n_preg;
    int owned[$];

    function automatic void model_reset();
        m_run = 0; m_first = 0; m_uf = 0; m_mm = 0; m_icnt = 0; m_free = NUM_PREGS;
        a_v = 0; a_lane = '0; a_preg = '0;
    endfunction

    always @(negedge clk) begin
        int nreq, nfree, net, k;
        bit rdy, gnt, fok, uf;
        logic [MAX_IO-1:0] eget, eput;
        if (!rst_n) begin
            model_reset();
            owned.delete();
        end
        nreq  = $countones(req_en);
        rdy   = m_run && !flush && !reinit && (nreq + RES <= m_free);
        gnt   = rdy && (nreq > 0);
        fok   = m_run && !reinit;
        nfree = fok ? $countones(free_en) : 0;
        net   = m_free - (gnt ? nreq : 0) + nfree;
        uf    = (net > NUM_PREGS);
        eget  = gnt ? req_en : '0;
        eput  = (fok && !uf) ? free_en : '0;

        chk("fifo_rst", fifo_rst, !m_run);
        chk("req_ready", req_ready, rdy);
        chk("fifo_get_en", fifo_get_en, eget);
        chk("fifo_put_en", fifo_put_en, eput);
        for (int i = 0; i < MAX_IO; i++)
            if (eput[i]) chk("fifo_put", fifo_put[i], free_preg[i]);
        chk("alloc_valid", alloc_valid, a_v);
        chk("alloc_lane_en", alloc_lane_en, a_lane);
        chk("alloc_preg", alloc_preg, a_preg);
        chk("free_cnt", free_cnt, m_free);
        chk("err_underflow", err_underflow, m_uf);
        chk("err_mismatch", err_mismatch, m_mm);

        n_uf = m_uf || uf;
        n_mm = m_mm || (m_run && !m_first && (int'(fifo_len) != m_free));
        n_first = 0;
        n_run = m_run;
        n_icnt = m_icnt;
        n_free = m_free;
        if (!m_run) begin
            n_free = NUM_PREGS;
            n_icnt = m_icnt + 1;
            if (n_icnt >= INITC) begin n_run = 1; n_first = 1; n_icnt = 0; end
        end else if (reinit) begin
            n_run = 0; n_icnt = 0; n_free = NUM_PREGS;
            owned.delete();
        end else begin
            n_free = uf ? NUM_PREGS : net;
        end
        n_v = gnt;
        n_lane = eget;
        n_preg = '0;
        k = 0;
        for (int i = 0; i < MAX_IO; i++) begin
            if (gnt && req_en[i]) begin
                n_preg[i] = PREG_W'(fq[k]);
                owned.push_back(fq[k]);
                k++;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else begin
            m_run = n_run; m_first = n_first; m_uf = n_uf; m_mm = n_mm;
            m_icnt = n_icnt; m_free = n_free; a_v = n_v; a_lane = n_lane; a_preg = n_preg;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_init(input string name);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (fifo_rst !== 1'b1) break;
            cnt++;
            step();
        end
        chk(name, cnt, INITC);
    endtask

    initial begin
        int idx, pct, f0, f1;
        model_reset();
        step();
        chk("reset_free_cnt", free_cnt, NUM_PREGS);
        chk("reset_alloc_valid", alloc_valid, 0);
        chk("reset_fifo_rst", fifo_rst, 1);
        req_en = 3'b101;
        rst_n = 1'b1;
        count_init("init_cycles");
        chk("run_ready", req_ready, 1);
        chk("run_free_cnt", free_cnt, 64);
        step();
        req_en = '0;
        chk("first_valid", alloc_valid, 1);
        chk("first_lanes", alloc_lane_en, 3'b101);
        chk("first_preg0", alloc_preg[0], 0);
        chk("first_preg1", alloc_preg[1], 0);
        chk("first_preg2", alloc_preg[2], 1);
        chk("first_free_cnt", free_cnt, 62);
        step();
        chk("first_no_mismatch", err_mismatch, 0);

        // flush cancels the grant but still takes the free
        flush = 1'b1; req_en = 3'b011;
        free_en = 3'b001; free_preg[0] = PREG_W'(owned.pop_front());
        #1;
        chk("flush_ready", req_ready, 0);
        chk("flush_get", fifo_get_en, 0);
        step();
        flush = 1'b0; req_en = '0; free_en = '0;
        chk("flush_valid", alloc_valid, 0);
        chk("flush_free_cnt", free_cnt, 63);

        for (int c = 0; c < 4000; c++) begin
            pct = (c < 2000) ? 20 : 70;
            req_en = 3'($urandom_range(0, 7));
            flush = ($urandom_range(0, 9) == 0);
            reinit = m_run && ($urandom_range(0, 399) == 0);
            free_en = '0; free_preg = '0;
            if (m_run && !reinit) begin
                for (int i = 0; i < MAX_IO; i++) begin
                    if (owned.size() > 0 && $urandom_range(0, 99) < pct) begin
                        idx = $urandom_range(0, owned.size() - 1);
                        free_en[i] = 1'b1;
                        free_preg[i] = PREG_W'(owned[idx]);
                        owned.delete(idx);
                    end
                end
            end
            step();
        end
        req_en = '0; flush = 1'b0; reinit = 1'b0; free_en = '0;
        for (int i = 0; i < 20 && !m_run; i++) step();
        chk("post_random_run", fifo_rst, 0);

        // drain to two free entries, then a 3-lane request must stall
        for (int i = 0; i < 100 && m_free > 2; i++) begin
            idx = (m_free - 2 < 3) ? m_free - 2 : 3;
            req_en = 3'((1 << idx) - 1);
            step();
        end
        req_en = 3'b111;
        #1;
        chk("drain_free_cnt", free_cnt, 2);
        chk("stall_ready", req_ready, 0);
        chk("stall_get", fifo_get_en, 0);
        req_en = '0;
        for (int i = 0; i < 4; i++) begin
            free_en = 3'b011;
            free_preg[0] = PREG_W'(owned.pop_front());
            free_preg[1] = PREG_W'(owned.pop_front());
            step();
        end
        free_en = 3'b011;
        f0 = owned.pop_front(); f1 = owned.pop_front();
        free_preg[0] = PREG_W'(f0); free_preg[1] = PREG_W'(f1);
        req_en = 3'b111;
        #1;
        chk("mix_start_cnt", free_cnt, 10);
        chk("mix_ready", req_ready, 1);
        step();
        req_en = '0; free_en = '0;
        chk("mix_free_cnt", free_cnt, 9);
        for (int i = 0; i < MAX_IO; i++)
            chk("mix_not_freed", (int'(alloc_preg[i]) != f0) && (int'(alloc_preg[i]) != f1), 1);

        // reinit, then a double free at a full list
        reinit = 1'b1;
        step();
        reinit = 1'b0;
        count_init("reinit_cycles");
        chk("reinit_free_cnt", free_cnt, 64);
        free_en = 3'b001; free_preg[0] = 6'd5;
        #1;
        chk("uf_no_put", fifo_put_en, 0);
        step();
        free_en = '0;
        chk("uf_flag", err_underflow, 1);
        chk("uf_free_cnt", free_cnt, 64);
        step(); step();
        chk("uf_sticky", err_underflow, 1);

        // reserve instance: stalls when a request would dip into the reserve
        req_en_r = 3'b001;
        step();
        req_en_r = 3'b111;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (req_ready_r !== 1'b1) break;
            step();
        end
        chk("res_free_cnt", free_cnt_r, 3);
        chk("res_stall", req_ready_r, 0);
        chk("res_get", get_en_r, 0);
        req_en_r = 3'b011;
        #1;
        chk("res_fit2", req_ready_r, 1);
        step();
        req_en_r = 3'b001;
        #1;
        chk("res_cnt1", free_cnt_r, 1);
        chk("res_stall1", req_ready_r, 0);
        req_en_r = '0;

        // asynchronous reset while an allocation is pending
        req_en = 3'b001;
        step();
        req_en = '0;
        chk("pre_rst_valid", alloc_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_valid", alloc_valid, 0);
        chk("async_free_cnt", free_cnt, 64);
        chk("async_err_uf", err_underflow, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("end_err_mm", err_mismatch, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
